// File: rtl/divider_result_fixup_if.sv
// Operand/result bundle between the issuing logic, the divider core outputs and the fixup stage.
interface divider_result_fixup_if #(
    parameter int WIDTHN = 16,
    parameter int WIDTHD = 16,
    parameter int ERRW   = 16
);
    logic              clken;
    logic              in_valid;
    logic [WIDTHN-1:0] numer;
    logic [WIDTHD-1:0] denom;
    logic [WIDTHN-1:0] core_quotient;
    logic [WIDTHD-1:0] core_remain;
    logic [WIDTHN-1:0] quot_o;
    logic [WIDTHD-1:0] rem_o;
    logic              out_valid;
    logic              div_by_zero;
    logic              overflow;
    logic [ERRW-1:0]   err_count;

    modport master (
        output clken, in_valid, numer, denom, core_quotient, core_remain,
        input  quot_o, rem_o, out_valid, div_by_zero, overflow, err_count
    );

    modport slave (
        input  clken, in_valid, numer, denom, core_quotient, core_remain,
        output quot_o, rem_o, out_valid, div_by_zero, overflow, err_count
    );
endinterface

// File: rtl/divider_result_fixup.sv
// Result fixup after the divider core: carries operand sideband alongside the core pipeline,
// signs the remainder, forces divide-by-zero / overflow results and counts exceptions.
module divider_result_fixup #(
    parameter int WIDTHN  = 16,
    parameter int WIDTHD  = 16,
    parameter int LATENCY = 4,
    parameter int SIGNED  = 1,
    parameter int ERRW    = 16
) (
    input logic                clk,
    input logic                reset,
    divider_result_fixup_if.slave bus
);
    localparam logic              SGN          = (SIGNED != 0);
    localparam logic [WIDTHN-1:0] NUM_MOST_NEG = {1'b1, {(WIDTHN-1){1'b0}}};
    localparam logic [WIDTHN-1:0] QUOT_MAX_POS = {1'b0, {(WIDTHN-1){1'b1}}};

    logic [LATENCY-1:0] sb_valid;
    logic [LATENCY-1:0] sb_neg;
    logic [LATENCY-1:0] sb_dz;
    logic [LATENCY-1:0] sb_ovf;

    logic              cap_neg;
    logic              cap_dz;
    logic              cap_ovf;
    logic              tail_valid;
    logic              tail_neg;
    logic              tail_dz;
    logic              tail_ovf;
    logic [WIDTHD-1:0] rem_fixed;

    logic [WIDTHN-1:0] quot_q;
    logic [WIDTHD-1:0] rem_q;
    logic              valid_q;
    logic              dz_q;
    logic              ovf_q;
    logic [ERRW-1:0]   err_q;

    always_comb begin
        cap_neg    = SGN & bus.numer[WIDTHN-1];
        cap_dz     = (bus.denom == '0);
        cap_ovf    = SGN & (bus.numer == NUM_MOST_NEG) & (bus.denom == '1);
        tail_valid = sb_valid[LATENCY-1];
        tail_neg   = sb_neg[LATENCY-1];
        tail_dz    = sb_dz[LATENCY-1];
        tail_ovf   = sb_ovf[LATENCY-1];
        // Remainder takes the numerator's sign; a zero remainder never becomes negative.
        if (tail_neg && (bus.core_remain != '0)) begin
            rem_fixed = ~bus.core_remain + WIDTHD'(1);
        end else begin
            rem_fixed = bus.core_remain;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid <= '0;
            sb_neg   <= '0;
            sb_dz    <= '0;
            sb_ovf   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            valid_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= '0;
        end else begin
            valid_q <= bus.clken & tail_valid;
            if (bus.clken) begin
                sb_valid[0] <= bus.in_valid;
                sb_neg[0]   <= cap_neg;
                sb_dz[0]    <= cap_dz;
                sb_ovf[0]   <= cap_ovf;
                for (int i = 1; i < LATENCY; i++) begin
                    sb_valid[i] <= sb_valid[i-1];
                    sb_neg[i]   <= sb_neg[i-1];
                    sb_dz[i]    <= sb_dz[i-1];
                    sb_ovf[i]   <= sb_ovf[i-1];
                end
                if (tail_valid) begin
                    if (tail_dz) begin
                        quot_q <= '1;
                        rem_q  <= '0;
                        dz_q   <= 1'b1;
                        ovf_q  <= 1'b0;
                    end else if (tail_ovf) begin
                        quot_q <= QUOT_MAX_POS;
                        rem_q  <= '0;
                        dz_q   <= 1'b0;
                        ovf_q  <= 1'b1;
                    end else begin
                        quot_q <= bus.core_quotient;
                        rem_q  <= rem_fixed;
                        dz_q   <= 1'b0;
                        ovf_q  <= 1'b0;
                    end
                    if ((tail_dz || tail_ovf) && (err_q != '1)) begin
                        err_q <= err_q + ERRW'(1);
                    end
                end
            end
        end
    end

    assign bus.quot_o      = quot_q;
    assign bus.rem_o       = rem_q;
    assign bus.out_valid   = valid_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ovf_q;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_divider_result_fixup.sv
// Bench for divider_result_fixup: a behavioural divider core feeds the fixup stage,
// strobes are collected with their cycle stamp and compared against hand-computed tables.
module tb_divider_result_fixup;
    localparam int WN   = 16;
    localparam int WD   = 16;
    localparam int LAT  = 4;
    localparam int EW   = 16;
    localparam int EW_S = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    divider_result_fixup_if #(.WIDTHN(WN), .WIDTHD(WD), .ERRW(EW))   bus ();
    divider_result_fixup_if #(.WIDTHN(WN), .WIDTHD(WD), .ERRW(EW_S)) bus_s ();

    divider_result_fixup #(.WIDTHN(WN), .WIDTHD(WD), .LATENCY(LAT), .SIGNED(1), .ERRW(EW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    // Narrow error counter instance sees the same traffic so saturation is reachable quickly.
    divider_result_fixup #(.WIDTHN(WN), .WIDTHD(WD), .LATENCY(LAT), .SIGNED(1), .ERRW(EW_S)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    assign bus_s.clken         = bus.clken;
    assign bus_s.in_valid      = bus.in_valid;
    assign bus_s.numer         = bus.numer;
    assign bus_s.denom         = bus.denom;
    assign bus_s.core_quotient = bus.core_quotient;
    assign bus_s.core_remain   = bus.core_remain;

    function automatic logic [WN-1:0] core_q(logic [WN-1:0] n, logic [WD-1:0] d);
        int ni, di;
        ni = int'($signed(n));
        di = int'($signed(d));
        if (di == 0) return '0;
        return WN'(ni / di);
    endfunction

    function automatic logic [WD-1:0] core_r(logic [WN-1:0] n, logic [WD-1:0] d);
        int ni, di, r;
        ni = int'($signed(n));
        di = int'($signed(d));
        if (di == 0) return '0;
        r = ni % di;
        if (r < 0) r = -r;
        return WD'(r);
    endfunction

    logic [WN-1:0] cq [LAT];
    logic [WD-1:0] cr [LAT];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                cq[i] <= '0;
                cr[i] <= '0;
            end
        end else if (bus.clken) begin
            cq[0] <= core_q(bus.numer, bus.denom);
            cr[0] <= core_r(bus.numer, bus.denom);
            for (int i = 1; i < LAT; i++) begin
                cq[i] <= cq[i-1];
                cr[i] <= cr[i-1];
            end
        end
    end
    assign bus.core_quotient = cq[LAT-1];
    assign bus.core_remain   = cr[LAT-1];

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
        int          cyc;
    } strobe_t;

    typedef struct {
        logic [15:0] n;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
    } vec_t;

    strobe_t seen[$];
    vec_t    vecs[12];
    int      cyc = 0;
    int      total = 0;
    int      bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            strobe_t s;
            s.q   = bus.quot_o;
            s.r   = bus.rem_o;
            s.dz  = bus.div_by_zero;
            s.ovf = bus.overflow;
            s.cyc = cyc;
            seen.push_back(s);
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_strobe(string name, int idx, logic [15:0] q, logic [15:0] r,
                                logic dz, logic ovf, int ecyc);
        if (idx >= seen.size()) begin
            total++;
            bad++;
            $display("FAIL %s[%0d]: got %0d strobes required at least %0d", name, idx, seen.size(), idx + 1);
        end else begin
            check({name, ".q"},   32'(seen[idx].q), 32'(q));
            check({name, ".rem"}, 32'(seen[idx].r), 32'(r));
            check({name, ".dz"},  32'(seen[idx].dz), 32'(dz));
            check({name, ".ovf"}, 32'(seen[idx].ovf), 32'(ovf));
            check({name, ".cyc"}, 32'(seen[idx].cyc), 32'(ecyc));
        end
    endtask

    task automatic drive(logic ce, logic v, logic [15:0] n, logic [15:0] d);
        @(negedge clk);
        bus.clken    = ce;
        bus.in_valid = v;
        bus.numer    = n;
        bus.denom    = d;
    endtask

    task automatic idle(int k);
        repeat (k) drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Issue cnt table entries with gap bubbles between them; strobes follow LAT+1 edges later.
    task automatic run_burst(string name, int first, int cnt, int gap);
        int t0;
        seen.delete();
        t0 = 0;
        for (int i = 0; i < cnt; i++) begin
            drive(1'b1, 1'b1, vecs[first+i].n, vecs[first+i].d);
            if (i == 0) t0 = cyc;
            repeat (gap) drive(1'b1, 1'b0, 16'h0000, 16'h0000);
        end
        idle(LAT + 4);
        check({name, ".count"}, 32'(seen.size()), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            check_strobe(name, i, vecs[first+i].q, vecs[first+i].r, vecs[first+i].dz,
                         vecs[first+i].ovf, t0 + LAT + 1 + i * (gap + 1));
        end
    endtask

    initial begin
        int t0;
        vecs[0]  = '{16'h0008, 16'hFFFD, 16'hFFFE, 16'h0002, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFF3, 16'h0003, 16'hFFFC, 16'hFFFF, 1'b0, 1'b0};
        vecs[2]  = '{16'hFFF6, 16'hFFFB, 16'h0002, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{16'h0007, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1};
        vecs[5]  = '{16'h0009, 16'h0004, 16'h0002, 16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{16'hFFF0, 16'hFFFD, 16'h0005, 16'hFFFF, 1'b0, 1'b0};
        vecs[7]  = '{16'h000F, 16'hFFFF, 16'hFFF1, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};

        bus.clken    = 1'b0;
        bus.in_valid = 1'b0;
        bus.numer    = '0;
        bus.denom    = '0;
        repeat (3) @(negedge clk);
        check("reset.quot_o",    32'(bus.quot_o), 32'h0);
        check("reset.rem_o",     32'(bus.rem_o), 32'h0);
        check("reset.out_valid", 32'(bus.out_valid), 32'h0);
        check("reset.dz",        32'(bus.div_by_zero), 32'h0);
        check("reset.ovf",       32'(bus.overflow), 32'h0);
        check("reset.err_count", 32'(bus.err_count), 32'h0);
        reset = 1'b0;
        idle(2);

        run_burst("b2b", 0, 3, 0);
        check("b2b.err_count", 32'(bus.err_count), 32'd0);

        run_burst("exc", 3, 2, 0);
        check("exc.err_count",   32'(bus.err_count), 32'd2);
        check("exc.err_count_s", 32'(bus_s.err_count), 32'd2);

        // clken drops for three cycles after the second clken edge
        seen.delete();
        drive(1'b1, 1'b1, 16'h000F, 16'h0004);
        t0 = cyc;
        drive(1'b1, 1'b0, 16'h0000, 16'h0000);
        repeat (3) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        idle(8);
        check("stall.count", 32'(seen.size()), 32'd1);
        check_strobe("stall", 0, 16'h0003, 16'h0003, 1'b0, 1'b0, t0 + 8);

        run_burst("bubble", 5, 4, 1);
        check("bubble.err_count", 32'(bus.err_count), 32'd2);

        run_burst("sat", 9, 3, 0);
        check("sat.err_count",   32'(bus.err_count), 32'd5);
        check("sat.err_count_s", 32'(bus_s.err_count), 32'd3);

        // reset lands while three operations are still in flight
        seen.delete();
        drive(1'b1, 1'b1, 16'h0008, 16'hFFFD);
        drive(1'b1, 1'b1, 16'h0007, 16'h0000);
        drive(1'b1, 1'b1, 16'hFFF3, 16'h0003);
        drive(1'b1, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.err_count", 32'(bus.err_count), 32'd0);
        check("midrst.quot_o",    32'(bus.quot_o), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b1, 16'h0008, 16'hFFFD);
        t0 = cyc;
        idle(10);
        check("midrst.count", 32'(seen.size()), 32'd1);
        check_strobe("midrst", 0, 16'hFFFE, 16'h0002, 1'b0, 1'b0, t0 + LAT + 1);
        check("midrst.err_after",   32'(bus.err_count), 32'd0);
        check("midrst.err_after_s", 32'(bus_s.err_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
